// File: rtl/mem_stage_pkg.sv
// Shared encodings and helpers for the MEM stage: access sizes, byte enables,
// load extension and word-index width.
package mem_stage_pkg;

  localparam int NUM_LANES = 4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  function automatic int wordIdxW(input int depth);
    return $clog2(depth);
  endfunction

  // Half accesses key only on lane[1], so the low address bit is masked here.
  function automatic logic [NUM_LANES-1:0] byteEn(input logic [1:0] size,
                                                  input logic [1:0] lane);
    case (size)
      SZ_BYTE: return 4'b0001 << lane;
      SZ_HALF: return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] loadExt(input logic [31:0] word,
                                          input logic [1:0]  size,
                                          input logic [1:0]  lane,
                                          input logic        uns);
    logic [31:0] sh;
    logic [15:0] half;
    sh   = word >> {lane, 3'b000};
    half = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: return uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      SZ_HALF: return uns ? {16'h0, half}    : {{16{half[15]}}, half};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_pipe_if.sv
// EX->MEM payload with valid/ready, and MEM->WB payload with valid/ready.
interface mem_stage_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5
);
  logic              in_valid, in_ready;
  logic              mem_read, mem_write, mem_unsigned, reg_write;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] alu_result;
  logic [DATA_W-1:0] store_data;
  logic [REG_W-1:0]  wr_reg;
  logic [31:0]       pc_branch;

  logic              out_valid, out_ready;
  logic [DATA_W-1:0] out_mem_data;
  logic [ADDR_W-1:0] out_alu_result;
  logic [REG_W-1:0]  out_wr_reg;
  logic              out_reg_write, out_mem_to_reg, misalign;
  logic [31:0]       out_pc_branch;

  modport master (
    output in_valid, mem_read, mem_write, mem_size, mem_unsigned, reg_write,
           alu_result, store_data, wr_reg, pc_branch, out_ready,
    input  in_ready, out_valid, out_mem_data, out_alu_result, out_wr_reg,
           out_reg_write, out_mem_to_reg, out_pc_branch, misalign
  );

  modport slave (
    input  in_valid, mem_read, mem_write, mem_size, mem_unsigned, reg_write,
           alu_result, store_data, wr_reg, pc_branch, out_ready,
    output in_ready, out_valid, out_mem_data, out_alu_result, out_wr_reg,
           out_reg_write, out_mem_to_reg, out_pc_branch, misalign
  );
endinterface

// File: rtl/data_mem_bytelane.sv
// DEPTH x 32 single-port synchronous RAM, one 8-bit array per byte lane,
// read-before-write on a shared enable.
module data_mem_bytelane
  import mem_stage_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
)(
  input  logic                 clk,
  input  logic                 en,
  input  logic [NUM_LANES-1:0] we,
  input  logic [AW-1:0]        addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata
);
  logic [NUM_LANES-1:0][7:0] rdLane;

  for (genvar l = 0; l < NUM_LANES; l++) begin : gLane
    logic [7:0] mem [DEPTH];
    always_ff @(posedge clk) begin
      if (en) begin
        if (we[l]) mem[addr] <= wdata[8*l +: 8];
        rdLane[l] <= mem[addr];
      end
    end
  end

  assign rdata = rdLane;
endmodule

// File: rtl/mem_stage_pipe.sv
// MEM stage with MEM/WB register, internal byte-lane data memory and a
// valid/ready stall. Define MISALIGN_TRAP_EN to trap misaligned half/word.
module mem_stage_pipe
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 256,
  parameter int REG_W  = 5
)(
  input  logic           clk,
  input  logic           rst,
  mem_stage_pipe_if.slave bus
);
  localparam int WORD_IDX_W = wordIdxW(DEPTH);

  logic                 xfer, memEn, trap, isMem;
  logic [1:0]           lane;
  logic [NUM_LANES-1:0] we;
  logic [31:0]          wdata, rdata;
  logic                 vld, rRead, rWrite, rUns, rTrap;
  logic [1:0]           rSize, rLane;

  assign bus.in_ready = !vld || bus.out_ready;
  assign xfer         = bus.in_valid && bus.in_ready;
  assign memEn        = xfer && !rst;
  assign lane         = bus.alu_result[1:0];
  assign isMem        = bus.mem_read || bus.mem_write;

`ifdef MISALIGN_TRAP_EN
  assign trap = isMem && ((bus.mem_size == SZ_HALF && lane[0]) ||
                          (bus.mem_size[1] && lane != 2'b00));
`else
  assign trap = 1'b0;
`endif

  assign we = (memEn && bus.mem_write && !trap) ? byteEn(bus.mem_size, lane) : '0;

  always_comb begin
    case (bus.mem_size)
      SZ_BYTE: wdata = {4{bus.store_data[7:0]}};
      SZ_HALF: wdata = {2{bus.store_data[15:0]}};
      default: wdata = bus.store_data;
    endcase
  end

  data_mem_bytelane #(.DEPTH(DEPTH), .AW(WORD_IDX_W)) uMem (
    .clk   (clk),
    .en    (memEn),
    .we    (we),
    .addr  (bus.alu_result[2 +: WORD_IDX_W]),
    .wdata (wdata),
    .rdata (rdata)
  );

  // Sideband controls for the extension mux ride alongside the RAM read.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld                <= 1'b0;
      rRead              <= 1'b0;
      rWrite             <= 1'b0;
      rUns               <= 1'b0;
      rTrap              <= 1'b0;
      rSize              <= '0;
      rLane              <= '0;
      bus.out_alu_result <= '0;
      bus.out_wr_reg     <= '0;
      bus.out_reg_write  <= 1'b0;
      bus.out_mem_to_reg <= 1'b0;
      bus.out_pc_branch  <= '0;
    end else if (xfer) begin
      vld                <= 1'b1;
      rRead              <= bus.mem_read;
      rWrite             <= bus.mem_write;
      rUns               <= bus.mem_unsigned;
      rTrap              <= trap;
      rSize              <= bus.mem_size;
      rLane              <= lane;
      bus.out_alu_result <= bus.alu_result;
      bus.out_wr_reg     <= bus.wr_reg;
      bus.out_reg_write  <= bus.reg_write && !trap;
      bus.out_mem_to_reg <= bus.mem_read && !bus.mem_write;
      bus.out_pc_branch  <= bus.pc_branch;
    end else if (bus.out_ready) begin
      vld <= 1'b0;
    end
  end

  assign bus.out_valid    = vld;
  assign bus.out_mem_data = (rRead && !rWrite && !rTrap) ?
                            loadExt(rdata, rSize, rLane, rUns) : '0;

`ifdef MISALIGN_TRAP_EN
  assign bus.misalign = rTrap;
`else
  assign bus.misalign = 1'b0;
`endif
endmodule

// File: tb/tb_mem_stage_pipe.sv
// Scoreboard bench for mem_stage_pipe: directed loads/stores, stall, wrap,
// misalignment (both builds of MISALIGN_TRAP_EN) and reset-cycle store drop.
module tb_mem_stage_pipe;
  import mem_stage_pkg::*;

  typedef struct packed {
    logic [31:0] memData;
    logic [31:0] alu;
    logic [4:0]  wrReg;
    logic        regWrite;
    logic        memToReg;
    logic [31:0] pc;
    logic        mis;
  } exp_t;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_stage_pipe_if #(.DATA_W(32), .ADDR_W(32), .REG_W(5)) bus ();
  mem_stage_pipe #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .REG_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   nPc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per accepted MEM/WB payload.
  always @(negedge clk) begin : mon
    exp_t a, e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      a = '{memData: bus.out_mem_data, alu: bus.out_alu_result, wrReg: bus.out_wr_reg,
            regWrite: bus.out_reg_write, memToReg: bus.out_mem_to_reg,
            pc: bus.out_pc_branch, mis: bus.misalign};
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected actual alu=%h data=%h required no payload", a.alu, a.memData);
      end else begin
        e = q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL wb_payload actual data=%h alu=%h wr=%0d rw=%b m2r=%b pc=%h mis=%b required data=%h alu=%h wr=%0d rw=%b m2r=%b pc=%h mis=%b",
                   a.memData, a.alu, a.wrReg, a.regWrite, a.memToReg, a.pc, a.mis,
                   e.memData, e.alu, e.wrReg, e.regWrite, e.memToReg, e.pc, e.mis);
        end
      end
    end
  end

  task automatic drive(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic rw, input logic [31:0] addr, input logic [31:0] data,
                       input logic [31:0] expData, input logic mis, output exp_t e);
    bus.in_valid     = 1'b1;
    bus.mem_read     = rd;
    bus.mem_write    = wr;
    bus.mem_size     = sz;
    bus.mem_unsigned = uns;
    bus.reg_write    = rw;
    bus.alu_result   = addr;
    bus.store_data   = data;
    bus.wr_reg       = nPc[4:0];
    bus.pc_branch    = 32'h0040_0000 + 32'(nPc) * 4;
    e = '{memData: expData, alu: addr, wrReg: nPc[4:0], regWrite: rw & ~mis,
          memToReg: rd & ~wr, pc: 32'h0040_0000 + 32'(nPc) * 4, mis: mis};
    nPc++;
  endtask

  // Issue one payload, check 1-cycle latency, then leave one drain cycle.
  task automatic send(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                      input logic uns, input logic rw, input logic [31:0] addr,
                      input logic [31:0] data, input logic [31:0] expData, input logic mis);
    exp_t e;
    int   n;
    drive(rd, wr, sz, uns, rw, addr, data, expData, mis, e);
    n = 0;
    #1;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_accept_timeout actual in_ready=0 required 1", tag);
      bus.in_valid = 1'b0;
      return;
    end
    q.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk({tag, "_latency"}, 32'(bus.out_valid), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t e;
    bus.in_valid = 1'b0; bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_size = SZ_WORD;
    bus.mem_unsigned = 1'b0; bus.reg_write = 1'b0; bus.alu_result = '0; bus.store_data = '0;
    bus.wr_reg = '0; bus.pc_branch = '0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_misalign", 32'(bus.misalign), 32'd0);
    chk("rst_mem_data", bus.out_mem_data, 32'h0);
    chk("rst_alu", bus.out_alu_result, 32'h0);
    chk("rst_reg_write", 32'(bus.out_reg_write), 32'd0);

    //    tag         rd wr size     uns rw addr        data          expData       mis
    send("sw10",      0, 1, SZ_WORD, 0, 0, 32'h10,  32'hDEADBEEF, 32'h0,        0);
    send("lw10",      1, 0, SZ_WORD, 0, 1, 32'h10,  32'h0,        32'hDEADBEEF, 0);
    send("sb13",      0, 1, SZ_BYTE, 0, 0, 32'h13,  32'h12345680, 32'h0,        0);
    send("lb13",      1, 0, SZ_BYTE, 0, 1, 32'h13,  32'h0,        32'hFFFFFF80, 0);
    send("lbu13",     1, 0, SZ_BYTE, 1, 1, 32'h13,  32'h0,        32'h00000080, 0);
    send("lw10b",     1, 0, SZ_WORD, 0, 1, 32'h10,  32'h0,        32'h80ADBEEF, 0);
    send("lh12",      1, 0, SZ_HALF, 0, 1, 32'h12,  32'h0,        32'hFFFF80AD, 0);
    send("lhu10",     1, 0, SZ_HALF, 1, 1, 32'h10,  32'h0,        32'h0000BEEF, 0);
    send("rtype",     0, 0, SZ_WORD, 0, 1, 32'hABCD1234, 32'h0,   32'h0,        0);

    // Stall: load held with out_ready low while a store waits upstream.
    bus.out_ready = 1'b0;
    send("ld_stall",  1, 0, SZ_WORD, 0, 1, 32'h10,  32'h0,        32'h80ADBEEF, 0);
    drive(0, 1, SZ_WORD, 0, 0, 32'h10, 32'h77777777, 32'h0, 0, e);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_hold_data", bus.out_mem_data, 32'h80ADBEEF);
    end
    q.push_back(e);
    bus.out_ready = 1'b1;
    #1 chk("release_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("release_store_alu", bus.out_alu_result, 32'h10);
    @(posedge clk); #1;
    send("lw_after_stall", 1, 0, SZ_WORD, 0, 1, 32'h10, 32'h0, 32'h77777777, 0);

    // Misaligned half store.
    send("sw20",      0, 1, SZ_WORD, 0, 0, 32'h20,  32'hAAAAAAAA, 32'h0,        0);
    send("sh21",      0, 1, SZ_HALF, 0, 1, 32'h21,  32'h00001234, 32'h0,        TRAP);
    send("lw20",      1, 0, SZ_WORD, 0, 1, 32'h20,  32'h0,
         TRAP ? 32'hAAAAAAAA : 32'hAAAA1234, 0);

    // Address wrap modulo DEPTH*4.
    send("sw400",     0, 1, SZ_WORD, 0, 0, 32'h400, 32'h12345678, 32'h0,        0);
    send("lw000",     1, 0, SZ_WORD, 0, 1, 32'h000, 32'h0,        32'h12345678, 0);

    // Read+write together: store wins. Size 11 behaves as word.
    send("rdwr44",    1, 1, SZ_WORD, 0, 0, 32'h44,  32'h11112222, 32'h0,        0);
    send("lw44",      1, 0, SZ_WORD, 0, 1, 32'h44,  32'h0,        32'h11112222, 0);
    send("sw48_sz3",  0, 1, 2'b11,   0, 0, 32'h48,  32'h99887766, 32'h0,        0);
    send("lw48_sz3",  1, 0, 2'b11,   1, 1, 32'h48,  32'h0,        32'h99887766, 0);

    // Store presented in the reset cycle is dropped.
    send("sw30",      0, 1, SZ_WORD, 0, 0, 32'h30,  32'hCAFEF00D, 32'h0,        0);
    rst = 1'b1;
    drive(0, 1, SZ_WORD, 0, 0, 32'h30, 32'h0BADBEEF, 32'h0, 0, e);
    @(posedge clk); #1;
    chk("inrst_out_valid", 32'(bus.out_valid), 32'd0);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    chk("postrst_in_ready", 32'(bus.in_ready), 32'd1);
    send("lw30",      1, 0, SZ_WORD, 0, 1, 32'h30,  32'h0,        32'hCAFEF00D, 0);

    repeat (3) @(posedge clk);
    #1 chk("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual running required finished");
    $fatal(1);
  end
endmodule
